rf_multiport: RTL
=================

Name: rf_multiport

Overview:
Parametrised register file for the next-generation core datapath: NUM_RD read ports and one write port, with DEPTH = 2**ADDR_W entries of DATA_W bits.
- Registered (1-cycle) reads, same-cycle write forwarding, and an optional hardwired-zero entry 0.
- A halt-triggered dump sequencer streams every entry out for testbench and debug capture.
- Sits between the decode stage (read addresses) and the writeback stage (dst bus).

Parameters:
- DATA_W, 16: width of each register.
- ADDR_W, 4: address width; DEPTH = 2**ADDR_W.
- NUM_RD, 2: number of read ports (1..4).
- ZERO_REG, 1: when 1, entry 0 always reads 0 and ignores writes.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- re  in  NUM_RD  per-port read enable.
- raddr  in  NUM_RD*ADDR_W  read addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
- rdata  out  NUM_RD*DATA_W  registered read data; port i occupies bits [i*DATA_W +: DATA_W].
- we  in  1  write enable.
- waddr  in  ADDR_W  write address.
- wdata  in  DATA_W  write data (dst bus).
- hlt  in  1  halt request; starts a dump.
- dump_valid  out  1  dump_addr/dump_data are valid this cycle.
- dump_addr  out  ADDR_W  entry currently being dumped.
- dump_data  out  DATA_W  contents of dump_addr.
- dump_done  out  1  dump finished; held until hlt falls.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All entries cleared to 0.
  - rdata = 0.
  - Dump FSM in IDLE; dump_valid = 0, dump_addr = 0, dump_data = 0, dump_done = 0.
- Write:
  - At a clock edge with we=1 and FSM in IDLE, mem[waddr] <= wdata.
  - If ZERO_REG=1 and waddr=0, the write is dropped.
  - Writes are ignored in DUMP and DONE (the core is halted).
- Read:
  - At a clock edge with re[i]=1, rdata[i] <= value, visible the next cycle (latency 1).
  - With re[i]=0, rdata[i] holds its previous value.
  - ZERO_REG=1 and raddr[i]=0: value = 0, with priority over forwarding.
  - Otherwise, if forwarding applies (see Optional Feature): value = wdata.
  - Otherwise: value = mem[raddr[i]] before the current write.
- Multiple read ports may address the same entry; each is independent.
- Reads remain functional in every FSM state.
- Dump FSM states are IDLE, DUMP and DONE:
  - IDLE -> DUMP when hlt=1. The address counter is loaded with 0.
  - In DUMP, each cycle: dump_valid=1, dump_addr=cnt, dump_data=mem[cnt] (combinational read of the counter entry; entry 0 reads 0 if ZERO_REG), then cnt++.
  - DUMP -> DONE after cnt = DEPTH-1 has been presented. This gives exactly DEPTH valid cycles; no wrap.
  - In DONE: dump_done=1, dump_valid=0.
  - DONE -> IDLE when hlt=0.
  - If hlt drops during DUMP, the dump still completes, then DONE -> IDLE on the next cycle.
- Reset mid-dump: immediate return to IDLE and all storage cleared; a new dump needs a fresh hlt.

Optional Feature:
- Macro: RF_WR_BYPASS_EN.
- Defined: a read with re[i]=1, we=1, raddr[i]==waddr (FSM in IDLE) captures wdata in the same edge, so the write is visible at read latency 1.
- Undefined: no forwarding. The read captures the old mem contents; the new value is visible on the following read.
- The ZERO_REG rule applies in both cases.

Decomposition:
- Package rf_pkg holds:
  - default DATA_W/ADDR_W/NUM_RD constants;
  - the dump FSM state typedef (IDLE, DUMP, DONE);
  - a localparam helper for DEPTH.
- One sub-module, rf_dump_seq: dump FSM and address counter. It outputs the counter and control signals; the top level supplies mem data.

Test Plan:
- Reset, then write 0xBEEF to entry 5; next cycle re[0]=1, raddr0=5 -> rdata0=0xBEEF one cycle later; rdata0 holds when re[0] drops.
- Write 0x1234 to entry 0 with ZERO_REG=1; read entry 0 on both ports -> 0x0000.
- Same cycle: we=1, waddr=7, wdata=0xA5A5; raddr1=7, re[1]=1 (entry 7 previously 0x0001):
  - with RF_WR_BYPASS_EN -> rdata1=0xA5A5;
  - without -> 0x0001, and a re-read gives 0xA5A5.
- Fill entries 1..15 with values 0x0101*n, pulse hlt high:
  - 16 consecutive dump_valid cycles with addr 0..15 and data 0,0x0101..0x0F0F;
  - then dump_done held until hlt=0;
  - a write during the dump is ignored.
- Assert rst_n low at dump address 8 -> dump_valid=0, dump_done=0, all reads return 0; a re-issued hlt restarts at addr 0.
- NUM_RD=4, all ports reading distinct entries 2,3,4,5 in one cycle -> each port returns its own entry's value.

Source files
------------

// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared constants, dump FSM state type and depth helper for rf_multiport
package rf_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 4;
  localparam int NUM_RD_DEF = 2;

  // Number of entries addressed by an ADDR_W-bit address.
  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

  localparam int DEPTH_DEF = depth_of(ADDR_W_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DUMP = 2'd1,
    DONE = 2'd2
  } dump_state_t;

endpackage

// File: rtl/rf_dump_seq.sv
// rtl/rf_dump_seq.sv - halt-triggered dump FSM and entry address counter
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   hlt          halt request; starts a dump from IDLE, releases DONE when low
//   idle         FSM is in IDLE (writes allowed)
//   dump_valid   registered; high for exactly DEPTH cycles per dump
//   dump_done    registered; high in DONE until hlt falls
//   cnt          entry address being presented
module rf_dump_seq
  import rf_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hlt,
  output logic              idle,
  output logic              dump_valid,
  output logic              dump_done,
  output logic [ADDR_W-1:0] cnt
);

  dump_state_t state;

  // The last entry is the all-ones address, so the walk never wraps.
  localparam logic [ADDR_W-1:0] LAST = '1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      dump_valid <= 1'b0;
      dump_done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (hlt) begin
            state      <= DUMP;
            cnt        <= '0;
            dump_valid <= 1'b1;
          end
        end
        DUMP: begin
          // hlt is ignored here: a started dump always runs to the end.
          if (cnt == LAST) begin
            state      <= DONE;
            dump_valid <= 1'b0;
            dump_done  <= 1'b1;
          end else begin
            cnt <= cnt + ADDR_W'(1);
          end
        end
        DONE: begin
          if (!hlt) begin
            state     <= IDLE;
            dump_done <= 1'b0;
            cnt       <= '0;
          end
        end
        default: begin
          state      <= IDLE;
          cnt        <= '0;
          dump_valid <= 1'b0;
          dump_done  <= 1'b0;
        end
      endcase
    end
  end

  assign idle = (state == IDLE);

endmodule

// File: rtl/rf_multiport.sv
// rtl/rf_multiport.sv - NUM_RD-read / 1-write register file with halt-triggered dump
// Optional feature macro: RF_WR_BYPASS_EN (same-edge write-to-read forwarding).
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   re, raddr, rdata  per-port read enable, address, registered read data (packed per port)
//   we, waddr, wdata  write port (writeback dst bus), honoured only while the dump FSM is idle
//   hlt               halt request starting a dump of every entry
//   dump_valid/addr/data/done  dump stream and completion flag
module rf_multiport
  import rf_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = NUM_RD_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD-1:0]        re,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     hlt,
  output logic                     dump_valid,
  output logic [ADDR_W-1:0]        dump_addr,
  output logic [DATA_W-1:0]        dump_data,
  output logic                     dump_done
);

  localparam int DEPTH = depth_of(ADDR_W);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_val [NUM_RD];
  logic              idle;
  logic              wr_en;
  logic [ADDR_W-1:0] cnt;

  rf_dump_seq #(
    .ADDR_W(ADDR_W)
  ) u_dump_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .hlt       (hlt),
    .idle      (idle),
    .dump_valid(dump_valid),
    .dump_done (dump_done),
    .cnt       (cnt)
  );

  // The core is halted outside IDLE, so writes are dropped there.
  assign wr_en = we && idle && !((ZERO_REG != 0) && (waddr == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[waddr] <= wdata;
    end
  end

  // Read value per port; the zero-entry rule is applied last so it wins over forwarding.
  always_comb begin
    for (int i = 0; i < NUM_RD; i++) begin
      rd_val[i] = mem[raddr[i*ADDR_W +: ADDR_W]];
`ifdef RF_WR_BYPASS_EN
      if (we && idle && (raddr[i*ADDR_W +: ADDR_W] == waddr)) rd_val[i] = wdata;
`endif
      if ((ZERO_REG != 0) && (raddr[i*ADDR_W +: ADDR_W] == '0)) rd_val[i] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else begin
      for (int i = 0; i < NUM_RD; i++) begin
        if (re[i]) rdata[i*DATA_W +: DATA_W] <= rd_val[i];
      end
    end
  end

  assign dump_addr = cnt;
  assign dump_data = !dump_valid                            ? '0 :
                     ((ZERO_REG != 0) && (cnt == '0))       ? '0 :
                                                              mem[cnt];

endmodule
